// File: rtl/r5fp_pkg.sv
// Shared constants for the R5FP multiplier: rounding-mode codes, zStatus bit
// positions and the zStatus -> testfloat flag mapping.
package r5fp_pkg;

  localparam logic [2:0] RND_NE = 3'd0;  // nearest, ties to even
  localparam logic [2:0] RND_TZ = 3'd1;  // toward zero
  localparam logic [2:0] RND_UP = 3'd2;  // toward +inf
  localparam logic [2:0] RND_DN = 3'd3;  // toward -inf
  localparam logic [2:0] RND_NA = 3'd4;  // nearest, ties away from zero

  localparam int ZS_ZERO    = 0;
  localparam int ZS_INF     = 1;
  localparam int ZS_INVALID = 2;
  localparam int ZS_TINY    = 3;
  localparam int ZS_HUGE    = 4;
  localparam int ZS_INEXACT = 5;

  // testfloat order: {invalid, div-by-zero, overflow, underflow, inexact}
  function automatic logic [4:0] to_tf_flags(input logic [7:0] zs);
    return {zs[ZS_INVALID], 1'b0, zs[ZS_HUGE], zs[ZS_TINY], zs[ZS_INEXACT]};
  endfunction

endpackage

// File: rtl/r5fp_mul_pipe_if.sv
// Operand/result bundle for r5fp_mul_pipe. The master drives operands, the
// slave (the multiplier) returns the registered product and status.
interface r5fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23
);

  logic                   in_valid;
  logic [EXP_W+SIG_W:0]   a;
  logic [EXP_W+SIG_W:0]   b;
  logic [2:0]             rnd;
  logic                   out_valid;
  logic [EXP_W+SIG_W:0]   z;
  logic [7:0]             zStatus;

  modport master (
    output in_valid, a, b, rnd,
    input  out_valid, z, zStatus
  );

  modport slave (
    input  in_valid, a, b, rnd,
    output out_valid, z, zStatus
  );

endinterface

// File: rtl/r5fp_exp_incr.sv
// IEEE operand -> widened format (one extra exponent bit, bias 2^EXP_W-1).
// Subnormals are normalised here so the multiplier only ever sees an implicit
// leading one; zero, inf and NaN are classified for the special-case logic.
module r5fp_exp_incr #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23
) (
  input  logic [EXP_W+SIG_W:0] x_i,
  output logic                 sign_o,
  output logic [EXP_W:0]       exp_o,
  output logic [SIG_W-1:0]     frac_o,
  output logic                 zero_o,
  output logic                 inf_o,
  output logic                 nan_o,
  output logic                 snan_o
);

  localparam int LZW = $clog2(SIG_W + 1);
  localparam logic [EXP_W:0] EXP_OFF = (EXP_W+1)'(2 ** (EXP_W - 1));

  logic [EXP_W-1:0] e;
  logic [SIG_W-1:0] f;
  logic             e_max;
  logic             e_min;
  logic [LZW-1:0]   lz;
  logic [LZW-1:0]   sh;
  logic             found;

  assign sign_o = x_i[EXP_W+SIG_W];
  assign e      = x_i[EXP_W+SIG_W-1:SIG_W];
  assign f      = x_i[SIG_W-1:0];
  assign e_max  = &e;
  assign e_min  = ~|e;

  // leading-zero count of the stored fraction
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (f[i]) found = 1'b1;
        else      lz = lz + LZW'(1);
      end
    end
  end

  // classify the operand and produce the widened exponent/fraction
  always_comb begin
    sh     = lz + LZW'(1);
    zero_o = e_min && (f == '0);
    inf_o  = e_max && (f == '0);
    nan_o  = e_max && (f != '0);
    snan_o = nan_o && !f[SIG_W-1];
    exp_o  = {1'b0, e} + EXP_OFF;
    frac_o = f;
    if (zero_o) begin
      exp_o  = '0;
      frac_o = '0;
    end else if (e_max) begin
      exp_o  = '1;
    end else if (e_min) begin
      // leading one moves to the hidden position and drops out of the fraction
      exp_o  = EXP_OFF - (EXP_W+1)'(lz);
      frac_o = f << sh;
    end
  end

endmodule

// File: rtl/r5fp_mul_pipe.sv
// IEEE-754 multiplier with a registered result (latency 1).
// Build option R5FP_MUL_IN_REG_EN adds an input register stage (latency 2);
// the arithmetic is identical in both builds.
module r5fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23
) (
  input  logic            clk,
  input  logic            reset,
  r5fp_mul_pipe_if.slave  bus
);

  import r5fp_pkg::*;

  localparam int PW = 2 * SIG_W + 2;   // exact significand product
  localparam int W  = PW + 1;          // plus one bit of shift room
  localparam int IW = EXP_W + SIG_W + 1;
  // 2*widened bias - IEEE bias: turns ea+eb into an IEEE biased exponent
  localparam logic signed [EXP_W+2:0] KOFF =
    (EXP_W+3)'((2 ** EXP_W - 1) * 2 - (2 ** (EXP_W - 1) - 1));

  logic [IW-1:0] op_a;
  logic [IW-1:0] op_b;
  logic [2:0]    op_rnd;
  logic          op_vld;

`ifdef R5FP_MUL_IN_REG_EN
  logic [IW-1:0] a_q;
  logic [IW-1:0] b_q;
  logic [2:0]    rnd_q;
  logic          vld_in_q;

  // optional input stage, cleared by reset like the output stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      rnd_q    <= '0;
      vld_in_q <= 1'b0;
    end else begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      rnd_q    <= bus.rnd;
      vld_in_q <= bus.in_valid;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_rnd = rnd_q;
  assign op_vld = vld_in_q;
`else
  assign op_a   = bus.a;
  assign op_b   = bus.b;
  assign op_rnd = bus.rnd;
  assign op_vld = bus.in_valid;
`endif

  logic             sa, sb;
  logic [EXP_W:0]   ea, eb;
  logic [SIG_W-1:0] fa, fb;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

  r5fp_exp_incr #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_exp_a (
    .x_i(op_a), .sign_o(sa), .exp_o(ea), .frac_o(fa),
    .zero_o(zero_a), .inf_o(inf_a), .nan_o(nan_a), .snan_o(snan_a)
  );

  r5fp_exp_incr #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_exp_b (
    .x_i(op_b), .sign_o(sb), .exp_o(eb), .frac_o(fb),
    .zero_o(zero_b), .inf_o(inf_b), .nan_o(nan_b), .snan_o(snan_b)
  );

  logic [2:0]               rm;
  logic                     sgn;
  logic [PW-1:0]            prod;
  logic                     mbit;
  logic [PW-1:0]            m;
  logic signed [EXP_W+2:0]  exp_s;
  logic                     tiny_pre;
  logic [EXP_W+2:0]         dsh;
  logic [W-1:0]             v;
  logic [W-1:0]             v_sh;
  logic                     lost;
  logic                     rbit;
  logic                     sticky;
  logic                     lsb;
  logic                     inexact;
  logic                     inc;
  logic [EXP_W+1:0]         e_pre;
  logic [EXP_W+SIG_W+1:0]   rsum;
  logic [EXP_W+1:0]         re;
  logic [SIG_W-1:0]         rf;
  logic                     ovf;
  logic                     to_inf;
  logic                     inv_op;
  logic [IW-1:0]            z_d;
  logic [7:0]               zs_d;

  // multiply, denormalise if tiny, round once, narrow back and pick specials
  always_comb begin
    rm       = (op_rnd > RND_NA) ? RND_NE : op_rnd;
    sgn      = sa ^ sb;
    prod     = PW'({1'b1, fa}) * PW'({1'b1, fb});
    mbit     = prod[PW-1];
    m        = mbit ? prod : (prod << 1);
    exp_s    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - KOFF
             + $signed({{(EXP_W+2){1'b0}}, mbit});
    tiny_pre = exp_s[EXP_W+2] || (exp_s == '0);
    dsh      = tiny_pre ? ((EXP_W+3)'(1) - $unsigned(exp_s)) : '0;
    v        = {m, 1'b0};
    v_sh     = v >> dsh;
    lost     = ((v_sh << dsh) != v);
    lsb      = v_sh[SIG_W+2];
    rbit     = v_sh[SIG_W+1];
    sticky   = (|v_sh[SIG_W:0]) | lost;
    inexact  = rbit | sticky;

    case (rm)
      RND_TZ:  inc = 1'b0;
      RND_UP:  inc = inexact & ~sgn;
      RND_DN:  inc = inexact & sgn;
      RND_NA:  inc = rbit;
      default: inc = rbit & (sticky | lsb);
    endcase

    // a carry out of the fraction bumps the exponent, including subnormal->normal
    e_pre  = tiny_pre ? '0 : exp_s[EXP_W+1:0];
    rsum   = {e_pre, v_sh[W-2:SIG_W+2]} + (EXP_W+SIG_W+2)'(inc);
    re     = rsum[EXP_W+SIG_W+1:SIG_W];
    rf     = rsum[SIG_W-1:0];
    ovf    = re >= (EXP_W+2)'(2 ** EXP_W - 1);
    to_inf = (rm == RND_NE) || (rm == RND_NA)
          || ((rm == RND_UP) && !sgn) || ((rm == RND_DN) && sgn);
    inv_op = (inf_a && zero_b) || (zero_a && inf_b);

    z_d  = '0;
    zs_d = '0;
    if (nan_a || nan_b || inv_op) begin
      z_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
      zs_d[ZS_INVALID] = inv_op || snan_a || snan_b;
    end else if (inf_a || inf_b) begin
      z_d = {sgn, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      zs_d[ZS_INF] = 1'b1;
    end else if (zero_a || zero_b) begin
      z_d = {sgn, {(EXP_W+SIG_W){1'b0}}};
      zs_d[ZS_ZERO] = 1'b1;
    end else if (ovf) begin
      z_d = to_inf ? {sgn, {EXP_W{1'b1}}, {SIG_W{1'b0}}}
                   : {sgn, {(EXP_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}};
      zs_d[ZS_INF]     = to_inf;
      zs_d[ZS_HUGE]    = 1'b1;
      zs_d[ZS_INEXACT] = 1'b1;
    end else begin
      z_d = {sgn, re[EXP_W-1:0], rf};
      zs_d[ZS_ZERO]    = (re == '0) && (rf == '0);
      zs_d[ZS_TINY]    = (re == '0) && inexact;
      zs_d[ZS_INEXACT] = inexact;
    end
  end

  logic          vld_q;
  logic [IW-1:0] z_q;
  logic [7:0]    zs_q;

  // output register; result holds while no new operands arrive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      z_q   <= '0;
      zs_q  <= '0;
    end else begin
      vld_q <= op_vld;
      if (op_vld) begin
        z_q  <= z_d;
        zs_q <= zs_d;
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.z         = z_q;
  assign bus.zStatus   = zs_q;

endmodule

// File: tb/tb_r5fp_mul_pipe.sv
// Directed bench for r5fp_mul_pipe (single precision). Expected results are
// queued when operands are driven and checked when out_valid appears.
module tb_r5fp_mul_pipe;

  import r5fp_pkg::*;

  localparam int EXP_W = 8;
  localparam int SIG_W = 23;
`ifdef R5FP_MUL_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] z;
    logic [7:0]  zs;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   lat;
  logic [31:0] last_z;
  logic [7:0]  last_zs;

  r5fp_mul_pipe_if #(.EXP_W(EXP_W), .SIG_W(SIG_W)) dut_if ();

  r5fp_mul_pipe #(.EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pop_cmp();
    exp_t e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL sb_underflow: observed out_valid=1 expected nothing pending");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      assert (dut_if.z === e.z) else begin
        n_bad++;
        $error("FAIL %s z: observed %08h expected %08h", e.tag, dut_if.z, e.z);
      end
      n_cmp++;
      assert (dut_if.zStatus === e.zs) else begin
        n_bad++;
        $error("FAIL %s zStatus: observed %02h expected %02h", e.tag, dut_if.zStatus, e.zs);
      end
      last_z  = e.z;
      last_zs = e.zs;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (dut_if.out_valid) pop_cmp();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r,
                      input logic [31:0] ez, input logic [7:0] ezs, input string tag);
    exp_t e;
    tick();
    dut_if.in_valid = 1'b1;
    dut_if.a        = a;
    dut_if.b        = b;
    dut_if.rnd      = r;
    e.z   = ez;
    e.zs  = ezs;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic ev, input logic [31:0] ez,
                     input logic [7:0] ezs);
    n_cmp++;
    assert (dut_if.out_valid === ev) else begin
      n_bad++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, dut_if.out_valid, ev);
    end
    n_cmp++;
    assert (dut_if.z === ez) else begin
      n_bad++;
      $error("FAIL %s z: observed %08h expected %08h", tag, dut_if.z, ez);
    end
    n_cmp++;
    assert (dut_if.zStatus === ezs) else begin
      n_bad++;
      $error("FAIL %s zStatus: observed %02h expected %02h", tag, dut_if.zStatus, ezs);
    end
  endtask

  task automatic drain();
    tick();
    dut_if.in_valid = 1'b0;
    repeat (LAT + 2) tick();
    n_cmp++;
    assert (sb.size() === 0) else begin
      n_bad++;
      $error("FAIL drain: observed %0d results outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_z  = '0;
    last_zs = '0;
    reset = 1'b0;
    dut_if.in_valid = 1'b0;
    dut_if.a   = '0;
    dut_if.b   = '0;
    dut_if.rnd = '0;

    #12;
    chk("reset_state", 1'b0, 32'h0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", 1'b0, 32'h0, 8'h00);

    // latency of the first result
    send(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00, "mul_1p5x2");
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      dut_if.in_valid = 1'b0;
    end while (!dut_if.out_valid && lat < 8);
    n_cmp++;
    assert (lat === LAT) else begin
      n_bad++;
      $error("FAIL latency: observed %0d expected %0d", lat, LAT);
    end
    if (dut_if.out_valid) pop_cmp();
    repeat (LAT) @(negedge clk);
    n_cmp++;
    assert (dut_if.out_valid === 1'b0) else begin
      n_bad++;
      $error("FAIL out_valid_drop: observed %b expected 0", dut_if.out_valid);
    end

    // back-to-back stream; zStatus bits: 0 zero,1 inf,2 invalid,3 tiny,4 huge,5 inexact
    send(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20, "ne_sticky");
    send(32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 8'h20, "up_sticky");
    send(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h20, "tz_sticky");
    send(32'h3F800001, 32'h3F800001, 3'd4, 32'h3F800002, 8'h20, "na_sticky");
    send(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04, "inf_x_zero");
    send(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h00, "qnan_prop");
    send(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04, "snan_op");
    send(32'hFFC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h00, "neg_qnan");
    send(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 8'h02, "ninf_x_two");
    send(32'h00000000, 32'hC0000000, 3'd0, 32'h80000000, 8'h01, "zero_x_neg");
    send(32'hC0000000, 32'h40400000, 3'd0, 32'hC0C00000, 8'h00, "neg_six");
    send(32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 8'h00, "exact_subn");
    send(32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 8'h29, "uflow_ne");
    send(32'h00000001, 32'h3F000000, 3'd2, 32'h00000001, 8'h28, "uflow_up");
    send(32'h00000001, 32'h3F000000, 3'd4, 32'h00000001, 8'h28, "uflow_na");
    send(32'h00000001, 32'h3F000000, 3'd5, 32'h00000000, 8'h29, "uflow_rm5");
    send(32'h80000001, 32'h3F000000, 3'd3, 32'h80000001, 8'h28, "uflow_neg_dn");
    send(32'h80000001, 32'h3F000000, 3'd2, 32'h80000000, 8'h29, "uflow_neg_up");
    send(32'h00000003, 32'h40000000, 3'd0, 32'h00000006, 8'h00, "subn_x_two");
    send(32'h00000001, 32'h4B000000, 3'd0, 32'h00800000, 8'h00, "subn_to_norm");
    send(32'h007FFFFF, 32'h3F800001, 3'd2, 32'h00800000, 8'h20, "round_to_norm");
    send(32'h007FFFFF, 32'h3F800001, 3'd1, 32'h007FFFFF, 8'h28, "stay_subn");
    send(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 8'h30, "ovf_tz");
    send(32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF7FFFFF, 8'h30, "ovf_neg_up");
    send(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF800000, 8'h32, "ovf_neg_dn");
    send(32'h7F7FFFFF, 32'h40000000, 3'd2, 32'h7F800000, 8'h32, "ovf_pos_up");
    send(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 8'h32, "ovf_ne");
    drain();

    // result holds with in_valid low
    repeat (3) @(negedge clk);
    chk("hold", 1'b0, last_z, last_zs);
    n_cmp++;
    assert (to_tf_flags(dut_if.zStatus) === 5'b00101) else begin
      n_bad++;
      $error("FAIL tf_flags: observed %05b expected 00101", to_tf_flags(dut_if.zStatus));
    end

    // reset asserted while out_valid is high
    tick();
    dut_if.in_valid = 1'b1;
    dut_if.a   = 32'h40000000;
    dut_if.b   = 32'h40400000;
    dut_if.rnd = 3'd0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      dut_if.in_valid = 1'b0;
    end while (!dut_if.out_valid && lat < 8);
    n_cmp++;
    assert (dut_if.out_valid === 1'b1 && dut_if.z === 32'h40C00000) else begin
      n_bad++;
      $error("FAIL rst_pre: observed valid=%b z=%08h expected valid=1 z=40c00000",
             dut_if.out_valid, dut_if.z);
    end
    #2 reset = 1'b0;
    #1 chk("rst_async", 1'b0, 32'h0, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_held", 1'b0, 32'h0, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_release_idle", 1'b0, 32'h0, 8'h00);

    send(32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 8'h00, "after_reset");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/r5fp_mul_pipe.md
# r5fp_mul_pipe

Parameterised IEEE-754 binary floating-point multiplier (default single precision) with a registered output. It sits in the R5FP arithmetic cluster. Operands are widened by one exponent bit so subnormals become normalised, multiplied exactly, rounded once under a selectable mode, narrowed back to IEEE format, and then registered together with the exception flags.

## Interface
- EXP_W, 8, IEEE exponent width
- SIG_W, 23, IEEE stored fraction width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid this cycle
- a, b  in  EXP_W+SIG_W+1  IEEE operands {sign, exp, frac}
- rnd  in  3  rounding mode
- out_valid  out  1  z/zStatus valid
- z  out  EXP_W+SIG_W+1  IEEE product
- zStatus  out  8  exception/status flags

## Operation
- Widen each operand to an EXP_W+1 exponent with bias 2^EXP_W−1.
  - Normal operand: exp + 2^(EXP_W−1).
  - Subnormal operand: shift left by (leading zeros of frac)+1, decrement the exponent to match.
  - Zero operand: exponent 0.
  - Inf/NaN operand: exponent all-ones, frac kept.
- Sign is a.sign XOR b.sign, including zero results.
- Significand product: (1.fa)×(1.fb) is exact at 2·SIG_W+2 bits, then one guard/sticky bit, 2·SIG_W+3 bits total. Normalise by ≤1 bit.
- Rounding happens once, at the IEEE precision. Tiny results are denormalised first, with shifted-out bits ORed into sticky, then rounded.
- rnd encoding:
  - 0 = nearest-even
  - 1 = toward zero
  - 2 = toward +inf
  - 3 = toward −inf
  - 4 = nearest-ties-away
  - 5–7 behave as 0
- Specials:
  - Any NaN operand, or inf×0, gives canonical NaN: sign 0, exp all-ones, frac MSB 1, rest 0.
  - invalid is set for inf×0 or a signalling NaN operand (frac MSB 0). A quiet NaN propagates without invalid.
  - inf×finite-nonzero gives inf with no flags.
  - An exact zero gives zero with no flags.
- Overflow sets huge and inexact. The result depends on the mode:
  - Modes 0 and 4: ±inf.
  - Mode 1: ±max finite.
  - Mode 2: +inf for positive results, −max finite for negative.
  - Mode 3: mirror of mode 2.
- zStatus bits:
  - [0] zero
  - [1] inf
  - [2] invalid
  - [3] tiny: final exponent field is 0 and the result is inexact. Never set when the rounded result is normal.
  - [4] huge
  - [5] inexact
  - [7:6] always 0
- Testfloat flag mapping is {invalid, 0, huge, tiny, inexact}.

## Timing
- Combinational path from a/b/rnd to the output register. Latency is 1 cycle: operands sampled at edge N appear on z/zStatus after edge N.
- out_valid is in_valid delayed by one cycle. When in_valid is low, z and zStatus hold their last value.
- No backpressure; a new operand pair is accepted every cycle.
- Reset asserted, including mid-stream: out_valid, z and zStatus go to 0 immediately and stay 0 until the first in_valid after release.

## Configuration
- R5FP_MUL_IN_REG_EN defined: a, b, rnd and in_valid are registered first, giving latency 2. The input registers reset to 0.
- R5FP_MUL_IN_REG_EN undefined: latency 1 as above.
- Results are identical in both builds; only latency differs.

## Structure
- Package r5fp_pkg holds:
  - rounding-mode constants RND_NE, RND_TZ, RND_UP, RND_DN, RND_NA
  - zStatus bit indices
  - a function mapping zStatus to testfloat flags
- One sub-module, r5fp_exp_incr, handles IEEE-to-widened conversion with subnormal normalisation and is instantiated for a and b.
- Multiply, round and narrow-back logic is inline in r5fp_mul_pipe.

## Test plan
All vectors use EXP_W=8 and SIG_W=23. Flags are listed by zStatus bit name.
- 0x3FC00000 × 0x40000000, rnd 0 → z=0x40400000, zStatus=0, out_valid one cycle after in_valid.
- 0x3F800001 × 0x3F800001:
  - rnd 0 → z=0x3F800002, inexact.
  - rnd 2 → z=0x3F800003, inexact.
- 0x7F800000 × 0x00000000 → z=0x7FC00000, invalid. 0x7FC00000 × 0x3F800000 → z=0x7FC00000, no invalid.
- 0x7F7FFFFF × 0x40000000:
  - rnd 0 → z=0x7F800000, huge and inexact.
  - rnd 1 → z=0x7F7FFFFF, huge and inexact.
- Tiny/underflow cases with 0x3F000000 as multiplier:
  - 0x00800000 × 0x3F000000 → z=0x00400000, no tiny (exact).
  - 0x00000001 × 0x3F000000, rnd 0 → z=0x00000000, tiny, inexact, zero.
  - 0x00000001 × 0x3F000000, rnd 2 → z=0x00000001, tiny and inexact.
- Reset: drive reset low while out_valid=1 → z, zStatus and out_valid read 0 before the next edge. Release reset with in_valid low → outputs stay 0.
